// File: rtl/pip_pkg.sv
// Shared pipeline definitions: data-memory size/sign codes and LSU state encoding.
package pip_pkg;

  // DM_ctrl encodings; any other code behaves as a word access.
  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} dm_size_e;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} lsu_state_e;

  // Access size implied by a DM_ctrl code.
  function automatic dm_size_e dm_size(input logic [2:0] ctrl);
    case (ctrl)
      DM_B, DM_BU: return SzByte;
      DM_H, DM_HU: return SzHalf;
      DM_W:        return SzWord;
      default:     return SzWord;
    endcase
  endfunction

  // Loads that zero-extend.
  function automatic logic dm_unsigned(input logic [2:0] ctrl);
    return (ctrl == DM_BU) || (ctrl == DM_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extension and misalignment detection (combinational).
module lsu_align
  import pip_pkg::*;
(
  input  logic [2:0]  req_ctrl_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_ctrl_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] rdata_sh;

  // Byte enables, replicated store data and alignment check for the access in MEM.
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = req_wdata_i;
    misalign_o = 1'b0;
    unique case (dm_size(req_ctrl_i))
      SzByte: begin
        be_o    = 4'b0001 << req_off_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      SzHalf: begin
        be_o       = 4'b0011 << req_off_i;
        wdata_o    = {2{req_wdata_i[15:0]}};
        misalign_o = req_off_i[0];
      end
      default: misalign_o = |req_off_i;
    endcase
  end

  // Select the addressed lane(s) of the read word and sign/zero extend.
  always_comb begin
    rdata_sh  = rdata_i >> {ld_off_i, 3'b000};
    ld_data_o = rdata_i;
    unique case (dm_size(ld_ctrl_i))
      SzByte: ld_data_o = dm_unsigned(ld_ctrl_i) ? {24'b0, rdata_sh[7:0]}
                                                 : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      SzHalf: ld_data_o = dm_unsigned(ld_ctrl_i) ? {16'b0, rdata_sh[15:0]}
                                                 : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/pip_mem_lsu.sv
// MEM-stage load/store unit: one req/ack bus transaction per access, pipeline hold,
// misalignment and timeout reporting.
module pip_mem_lsu
  import pip_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_out_p_i,
  input  logic [31:0] rs2_p_i,
  input  logic        dm_read_p_i,
  input  logic        dm_write_en_p_i,
  input  logic [2:0]  dm_ctrl_p_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_ack_i,
  input  logic [31:0] dm_rdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  lsu_state_e  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic        req_q, we_q, load_valid_q, misalign_q, bus_err_q, mis_seen_q;
  logic [31:0] addr_q, wdata_q, load_data_q;
  logic [3:0]  be_q;
  logic [2:0]  ctrl_q;
  logic [1:0]  off_q;

  logic        access, mis_now;
  logic [3:0]  be_now;
  logic [31:0] wdata_now, ld_ext;

  assign access = dm_read_p_i | dm_write_en_p_i;

  lsu_align u_align (
    .req_ctrl_i  (dm_ctrl_p_i),
    .req_off_i   (alu_out_p_i[1:0]),
    .req_wdata_i (rs2_p_i),
    .be_o        (be_now),
    .wdata_o     (wdata_now),
    .misalign_o  (mis_now),
    .ld_ctrl_i   (ctrl_q),
    .ld_off_i    (off_q),
    .rdata_i     (dm_rdata_i),
    .ld_data_o   (ld_ext)
  );

  // Stall from the issue cycle through the last BUSY cycle; forced low while in reset.
  always_comb begin
    lsu_stall_o = rst_n & ((state_q == StBusy) ||
                           ((state_q == StIdle) && access && !mis_now));
  end

  assign dm_req_o     = req_q;
  assign dm_we_o      = we_q;
  assign dm_addr_o    = addr_q;
  assign dm_be_o      = be_q;
  assign dm_wdata_o   = wdata_q;
  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

  // Access FSM with bus latches, timeout counter and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      ctrl_q       <= '0;
      off_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      mis_seen_q   <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!access) begin
            // Pipeline moved on: a later misaligned access may be flagged again.
            mis_seen_q <= 1'b0;
          end else if (!mis_now) begin
            req_q      <= 1'b1;
            we_q       <= dm_write_en_p_i;
            addr_q     <= {alu_out_p_i[31:2], 2'b00};
            be_q       <= be_now;
            wdata_q    <= wdata_now;
            ctrl_q     <= dm_ctrl_p_i;
            off_q      <= alu_out_p_i[1:0];
            cnt_q      <= '0;
            mis_seen_q <= 1'b0;
            state_q    <= StBusy;
          end else if (!mis_seen_q) begin
            misalign_q <= 1'b1;
            mis_seen_q <= 1'b1;
          end
        end
        StBusy: begin
          // Ack is tested first so it wins over a coincident timeout.
          if (dm_ack_i) begin
            req_q <= 1'b0;
            if (!we_q) begin
              load_data_q  <= ld_ext;
              load_valid_q <= 1'b1;
            end
            state_q <= StDone;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            req_q       <= 1'b0;
            bus_err_q   <= 1'b1;
            load_data_q <= '0;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pip_mem_lsu.sv
// Self-checking bench for pip_mem_lsu: vector table plus load scoreboard and reset sequence.
module tb_pip_mem_lsu;
  import pip_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_out, rs2, bus_rdata;
  logic        rd, wr, auto_ack, man_ack;
  logic [2:0]  ctrl;
  logic        dm_req, dm_we, lsu_stall, load_valid, misalign, bus_err;
  logic [31:0] dm_addr, dm_wdata, load_data;
  logic [3:0]  dm_be;
  logic        dm_ack;

  int n_checks = 0;
  int n_pass = 0;
  int ack_lat = 1000;
  int req_cnt = 0;
  logic [31:0] exp_q[$];
  logic lv_prev = 1'b0, mis_prev = 1'b0, err_prev = 1'b0;

  assign dm_ack = auto_ack | man_ack;

  always #5 clk = ~clk;

  pip_mem_lsu #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_out_p_i     (alu_out),
    .rs2_p_i         (rs2),
    .dm_read_p_i     (rd),
    .dm_write_en_p_i (wr),
    .dm_ctrl_p_i     (ctrl),
    .dm_req_o        (dm_req),
    .dm_we_o         (dm_we),
    .dm_addr_o       (dm_addr),
    .dm_be_o         (dm_be),
    .dm_wdata_o      (dm_wdata),
    .dm_ack_i        (dm_ack),
    .dm_rdata_i      (bus_rdata),
    .lsu_stall_o     (lsu_stall),
    .load_data_o     (load_data),
    .load_valid_o    (load_valid),
    .misalign_o      (misalign),
    .bus_err_o       (bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bus slave: pulse ack in the ack_lat-th cycle that dm_req has been high.
  always @(posedge clk) begin
    #1;
    if (dm_req && !auto_ack) begin
      req_cnt++;
      auto_ack = (req_cnt == ack_lat);
    end else begin
      req_cnt  = 0;
      auto_ack = 1'b0;
    end
  end

  // Scoreboard consumer and pulse-width monitor.
  always @(negedge clk) begin
    if (load_valid) begin
      if (exp_q.size() == 0) check("lv_unexpected", 32'd1, 32'd0);
      else check("load_data", load_data, exp_q.pop_front());
      check("lv_width", {31'b0, lv_prev}, 32'd0);
    end
    if (misalign) check("mis_width", {31'b0, mis_prev}, 32'd0);
    if (bus_err)  check("err_width", {31'b0, err_prev}, 32'd0);
    lv_prev  = load_valid;
    mis_prev = misalign;
    err_prev = bus_err;
  end

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;
    int          ack_lat;
    logic        exp_mis;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
    int          exp_stall;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                              input logic r, input logic w, input logic [31:0] rdv, input int lat,
                              input logic em, input logic ee, input logic [3:0] be,
                              input logic [31:0] ewd, input logic [31:0] eld, input int est);
    vec_t v;
    v.ctrl = c; v.addr = a; v.rs2 = d; v.rd = r; v.wr = w; v.rdata = rdv; v.ack_lat = lat;
    v.exp_mis = em; v.exp_err = ee; v.exp_be = be; v.exp_wdata = ewd; v.exp_ld = eld;
    v.exp_stall = est;
    return v;
  endfunction

  // Drive one access at the next edge and follow it through to DONE (or the misalign pulse).
  task automatic run_vec(input vec_t v, input int idx);
    int stall_cnt = 0, mis_cnt = 0, req_cyc = -1, err_cyc = -1;
    bit done = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    alu_out = v.addr; rs2 = v.rs2; rd = v.rd; wr = v.wr; ctrl = v.ctrl;
    bus_rdata = v.rdata; ack_lat = v.ack_lat;
    if (v.rd && !v.wr && !v.exp_mis && !v.exp_err) exp_q.push_back(v.exp_ld);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) check({tag, "_req_at_issue"}, {31'b0, dm_req}, 32'd0);
      if (lsu_stall) stall_cnt++;
      if (misalign) mis_cnt++;
      if (bus_err && err_cyc < 0) err_cyc = c;
      if (dm_req && req_cyc < 0) begin
        req_cyc = c;
        check({tag, "_addr"}, dm_addr, {v.addr[31:2], 2'b00});
        check({tag, "_be"}, {28'b0, dm_be}, {28'b0, v.exp_be});
        check({tag, "_we"}, {31'b0, dm_we}, {31'b0, v.wr});
        if (v.wr) check({tag, "_wdata"}, dm_wdata, v.exp_wdata);
      end
      if (v.exp_mis) done = (c == 4);
      else if (c > 0 && !lsu_stall) done = 1;
    end
    if (!done) check({tag, "_complete"}, 32'd0, 32'd1);
    check({tag, "_stall_cycles"}, stall_cnt, v.exp_stall);
    if (v.exp_mis) begin
      check({tag, "_mis_pulses"}, mis_cnt, 32'd1);
      check({tag, "_no_req"}, {31'b0, req_cyc >= 0}, 32'd0);
      @(posedge clk); #1;
      rd = 0; wr = 0;
    end else begin
      check({tag, "_req_dropped"}, {31'b0, dm_req}, 32'd0);
      check({tag, "_lv"}, {31'b0, load_valid}, {31'b0, v.rd && !v.wr && !v.exp_err});
      check({tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, v.exp_err});
      if (v.exp_err) check({tag, "_err_delay"}, err_cyc - req_cyc, 32'd16);
    end
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_out = 32'h0; rs2 = 32'h0; rd = 0; wr = 0; ctrl = DM_W; bus_rdata = 32'h0;
    man_ack = 0; auto_ack = 0;

    //        ctrl  addr          rs2           rd wr rdata        lat mis err be     wdata         ld            stall
    vecs.push_back(mk(DM_W,  32'h104, 32'hDEADBEEF, 0, 1, 32'h0,        3, 0, 0, 4'hF, 32'hDEADBEEF, 32'h0,        4));
    vecs.push_back(mk(DM_B,  32'h203, 32'h0,        1, 0, 32'h80123456, 1, 0, 0, 4'h8, 32'h0,        32'hFFFFFF80, 2));
    vecs.push_back(mk(DM_BU, 32'h203, 32'h0,        1, 0, 32'h80123456, 1, 0, 0, 4'h8, 32'h0,        32'h00000080, 2));
    vecs.push_back(mk(DM_HU, 32'h202, 32'h0,        1, 0, 32'hBEEF0000, 2, 0, 0, 4'hC, 32'h0,        32'h0000BEEF, 3));
    vecs.push_back(mk(DM_H,  32'h200, 32'h0,        1, 0, 32'h12348001, 1, 0, 0, 4'h3, 32'h0,        32'hFFFF8001, 2));
    vecs.push_back(mk(DM_B,  32'h201, 32'h0,        1, 0, 32'h00007F00, 1, 0, 0, 4'h2, 32'h0,        32'h0000007F, 2));
    vecs.push_back(mk(DM_W,  32'h010, 32'h0,        1, 0, 32'hCAFEF00D, 1, 0, 0, 4'hF, 32'h0,        32'hCAFEF00D, 2));
    vecs.push_back(mk(DM_B,  32'h007, 32'h0000005A, 0, 1, 32'h0,        1, 0, 0, 4'h8, 32'h5A5A5A5A, 32'h0,        2));
    vecs.push_back(mk(DM_H,  32'h102, 32'h0000ABCD, 0, 1, 32'h0,        2, 0, 0, 4'hC, 32'hABCDABCD, 32'h0,        3));
    vecs.push_back(mk(DM_H,  32'h101, 32'h00001234, 0, 1, 32'h0,        1, 1, 0, 4'h0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(DM_W,  32'h102, 32'h0,        1, 0, 32'h0,        1, 1, 0, 4'h0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(DM_HU, 32'h203, 32'h0,        1, 0, 32'h0,        1, 1, 0, 4'h0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(3'b011, 32'h008, 32'h0,       1, 0, 32'h11223344, 1, 0, 0, 4'hF, 32'h0,        32'h11223344, 2));
    vecs.push_back(mk(DM_B,  32'h001, 32'h00000033, 1, 1, 32'h99999999, 1, 0, 0, 4'h2, 32'h33333333, 32'h0,        2));
    vecs.push_back(mk(DM_W,  32'h300, 32'h0,        1, 0, 32'h77777777, 1000, 0, 1, 4'hF, 32'h0,     32'h0,        17));
    vecs.push_back(mk(DM_W,  32'h024, 32'h0,        1, 0, 32'h55AA55AA, 16, 0, 0, 4'hF, 32'h0,       32'h55AA55AA, 17));
    vecs.push_back(mk(DM_W,  32'h020, 32'h0,        1, 0, 32'h0BADF00D, 1, 0, 0, 4'hF, 32'h0,        32'h0BADF00D, 2));

    // Reset state, with an aligned access presented while reset is held.
    repeat (2) @(posedge clk);
    #1; rd = 1; alu_out = 32'h40;
    @(negedge clk);
    check("rst_req", {31'b0, dm_req}, 32'd0);
    check("rst_stall", {31'b0, lsu_stall}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_pulses", {29'b0, load_valid, misalign, bus_err}, 32'd0);
    check("rst_be_addr", {dm_be, dm_addr[27:0]}, 32'd0);
    rd = 0;
    #2 rst_n = 1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset while BUSY, then a stray ack once idle.
    @(posedge clk); #1;
    ctrl = DM_W; alu_out = 32'h40; rd = 1; wr = 0; ack_lat = 1000;
    @(negedge clk); @(negedge clk);
    check("busy_req", {31'b0, dm_req}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("async_rst_req", {31'b0, dm_req}, 32'd0);
    check("async_rst_stall", {31'b0, lsu_stall}, 32'd0);
    @(posedge clk); #1; rd = 0;
    @(negedge clk); #2 rst_n = 1;
    @(posedge clk); #1; man_ack = 1; bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1; man_ack = 0;
    @(negedge clk);
    check("late_ack_req", {31'b0, dm_req}, 32'd0);
    check("late_ack_stall", {31'b0, lsu_stall}, 32'd0);
    check("late_ack_lv", {31'b0, load_valid}, 32'd0);
    run_vec(mk(DM_BU, 32'h041, 32'h0, 1, 0, 32'h0000C300, 1, 0, 0, 4'h2, 32'h0, 32'h000000C3, 2),
            99);

    @(posedge clk); #1; rd = 0; wr = 0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
